// File: rtl/fb_rect_fill_if.sv
// Command and frame-buffer write-port bundle for the rectangle-fill engine.
// master = command source / arbiter side, slave = fill engine side.
interface fb_rect_fill_if #(
    parameter int ADDR_W = 17,
    parameter int PIX_W  = 12
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [8:0]        cmd_x0;
    logic [7:0]        cmd_y0;
    logic [8:0]        cmd_w;
    logic [7:0]        cmd_h;
    logic [PIX_W-1:0]  cmd_color;
    logic              fb_wen;
    logic              fb_grant;
    logic [ADDR_W-1:0] fb_addr;
    logic [PIX_W-1:0]  fb_din;

    modport master (
        output cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color, fb_grant,
        input  cmd_ready, fb_wen, fb_addr, fb_din
    );

    modport slave (
        input  cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color, fb_grant,
        output cmd_ready, fb_wen, fb_addr, fb_din
    );
endinterface

// File: rtl/fb_rect_fill.sv
// Solid-colour rectangle fill into a 320x240x12 frame buffer, one pixel per granted cycle.
// Optional macro FB_RECT_FILL_VBLANK_SYNC_EN holds the fill until vertical blank.
module fb_rect_fill #(
    parameter int H_RES  = 320,
    parameter int V_RES  = 240,
    parameter int ADDR_W = 17,
    parameter int PIX_W  = 12
) (
    input  logic          clock,
    input  logic          reset,
    fb_rect_fill_if.slave bus,
    output logic          busy,
    output logic          done_int,
    input  logic          vblank
);

`ifdef FB_RECT_FILL_VBLANK_SYNC_EN
    typedef enum logic [2:0] {IDLE, SETUP, FILL, DONE, WAIT_VBL} state_t;
`else
    typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;
    logic unused_vblank;
    assign unused_vblank = vblank;
`endif

    state_t            state_reg;
    logic [8:0]        x0_reg;
    logic [7:0]        y0_reg;
    logic [8:0]        w_reg;
    logic [7:0]        h_reg;
    logic [PIX_W-1:0]  color_reg;
    logic [8:0]        w_eff_reg;
    logic [7:0]        h_eff_reg;
    logic [8:0]        col_reg;
    logic [7:0]        row_reg;
    logic [ADDR_W-1:0] row_base_reg;
    logic [ADDR_W-1:0] fb_addr_reg;
    logic [PIX_W-1:0]  fb_din_reg;
    logic              fb_wen_reg;
    logic              cmd_ready_reg;
    logic              busy_reg;
    logic              done_reg;

    logic [9:0]        x_room_next;
    logic [8:0]        y_room_next;
    logic [8:0]        w_eff_next;
    logic [7:0]        h_eff_next;
    logic [ADDR_W-1:0] base_next;
    logic [ADDR_W-1:0] row_base_next;
    logic              empty_next;
    logic              last_col;
    logic              last_row;

    // Clipping is only meaningful when the origin is on screen; empty_next covers the rest.
    always_comb begin
        x_room_next   = 10'(H_RES) - {1'b0, x0_reg};
        y_room_next   = 9'(V_RES) - {1'b0, y0_reg};
        w_eff_next    = ({1'b0, w_reg} > x_room_next) ? x_room_next[8:0] : w_reg;
        h_eff_next    = ({1'b0, h_reg} > y_room_next) ? y_room_next[7:0] : h_reg;
        base_next     = ADDR_W'(y0_reg) * ADDR_W'(H_RES) + ADDR_W'(x0_reg);
        row_base_next = row_base_reg + ADDR_W'(H_RES);
        empty_next    = ({1'b0, x0_reg} >= 10'(H_RES)) || ({1'b0, y0_reg} >= 9'(V_RES)) ||
                        (w_reg == 9'd0) || (h_reg == 8'd0);
        last_col      = (col_reg == w_eff_reg - 9'd1);
        last_row      = (row_reg == h_eff_reg - 8'd1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            x0_reg        <= '0;
            y0_reg        <= '0;
            w_reg         <= '0;
            h_reg         <= '0;
            color_reg     <= '0;
            w_eff_reg     <= '0;
            h_eff_reg     <= '0;
            col_reg       <= '0;
            row_reg       <= '0;
            row_base_reg  <= '0;
            fb_addr_reg   <= '0;
            fb_din_reg    <= '0;
            fb_wen_reg    <= 1'b0;
            cmd_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        x0_reg        <= bus.cmd_x0;
                        y0_reg        <= bus.cmd_y0;
                        w_reg         <= bus.cmd_w;
                        h_reg         <= bus.cmd_h;
                        color_reg     <= bus.cmd_color;
                        cmd_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        state_reg     <= SETUP;
                    end
                end
                SETUP: begin
                    w_eff_reg    <= w_eff_next;
                    h_eff_reg    <= h_eff_next;
                    row_base_reg <= base_next;
                    col_reg      <= '0;
                    row_reg      <= '0;
                    fb_addr_reg  <= base_next;
                    fb_din_reg   <= color_reg;
                    if (empty_next) begin
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= DONE;
                    end else begin
`ifdef FB_RECT_FILL_VBLANK_SYNC_EN
                        state_reg  <= WAIT_VBL;
`else
                        fb_wen_reg <= 1'b1;
                        state_reg  <= FILL;
`endif
                    end
                end
`ifdef FB_RECT_FILL_VBLANK_SYNC_EN
                WAIT_VBL: begin
                    if (vblank) begin
                        fb_wen_reg <= 1'b1;
                        state_reg  <= FILL;
                    end
                end
`endif
                FILL: begin
                    // Without a grant the current address/data are simply held.
                    if (bus.fb_grant) begin
                        if (last_col) begin
                            if (last_row) begin
                                fb_wen_reg <= 1'b0;
                                done_reg   <= 1'b1;
                                busy_reg   <= 1'b0;
                                state_reg  <= DONE;
                            end else begin
                                col_reg      <= '0;
                                row_reg      <= row_reg + 8'd1;
                                row_base_reg <= row_base_next;
                                fb_addr_reg  <= row_base_next;
                            end
                        end else begin
                            col_reg     <= col_reg + 9'd1;
                            fb_addr_reg <= fb_addr_reg + ADDR_W'(1);
                        end
                    end
                end
                DONE: begin
                    cmd_ready_reg <= 1'b1;
                    state_reg     <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_reg;
    assign bus.fb_wen    = fb_wen_reg;
    assign bus.fb_addr   = fb_addr_reg;
    assign bus.fb_din    = fb_din_reg;
    assign busy          = busy_reg;
    assign done_int      = done_reg;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Directed bench for fb_rect_fill: stimulus queues expected writes/latencies, a negedge
// monitor pops and compares them. Latencies are counted in clock edges after the handshake edge.
module tb_fb_rect_fill;
    logic clock;
    logic reset;
    logic busy;
    logic done_int;
    logic vblank;

    fb_rect_fill_if bus ();

    fb_rect_fill dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .busy     (busy),
        .done_int (done_int),
        .vblank   (vblank)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

`ifdef FB_RECT_FILL_VBLANK_SYNC_EN
    localparam int VBL = 1;
`else
    localparam int VBL = 0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int hs_cyc   = 0;
    int wr_count = 0;
    int cur_first = -3;   // >=0: expected first-write latency, -1: no write allowed, -3: don't care
    int exp_addr[$];
    int exp_data[$];
    int exp_first[$];
    int exp_done[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: writes, first-write latency, done pulses, handshakes
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.fb_wen && bus.fb_grant) begin
                wr_count++;
                if (exp_addr.size() == 0) begin
                    check("unexpected_write", bus.fb_addr, 32'hFFFF_FFFF);
                end else begin
                    int a;
                    int d;
                    a = exp_addr.pop_front();
                    d = exp_data.pop_front();
                    check("wr_addr", bus.fb_addr, a);
                    check("wr_data", bus.fb_din, d);
                    $display("write addr=%0d data=0x%03h", bus.fb_addr, bus.fb_din);
                end
            end
            if (bus.fb_wen) begin
                if (cur_first >= 0) begin
                    check("first_wen_latency", cyc - hs_cyc, cur_first);
                    cur_first = -2;
                end else if (cur_first == -1) begin
                    check("wen_on_empty_cmd", 1, 0);
                    cur_first = -2;
                end
            end
            if (done_int) begin
                if (exp_done.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    int e;
                    e = exp_done.pop_front();
                    if (e != -3) check("done_latency", cyc - hs_cyc, e);
                    $display("done_int after %0d edges", cyc - hs_cyc);
                end
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                hs_cyc    = cyc + 1;
                cur_first = (exp_first.size() != 0) ? exp_first.pop_front() : -3;
            end
        end
    end

    task automatic push_wr(input int a, input int d);
        exp_addr.push_back(a);
        exp_data.push_back(d);
    endtask

    // done_lat == -4: no done pulse expected
    task automatic issue(input int x0, input int y0, input int w, input int h, input int color,
                         input int first_lat, input int done_lat);
        int guard;
        bus.cmd_x0    = 9'(x0);
        bus.cmd_y0    = 8'(y0);
        bus.cmd_w     = 9'(w);
        bus.cmd_h     = 8'(h);
        bus.cmd_color = 12'(color);
        exp_first.push_back(first_lat);
        if (done_lat != -4) exp_done.push_back(done_lat);
        bus.cmd_valid = 1'b1;
        guard = 0;
        while (bus.cmd_ready !== 1'b1 && guard < 300) begin
            tick();
            guard++;
        end
        if (guard >= 300) check("cmd_accept_timeout", 0, 1);
        $display("cmd x0=%0d y0=%0d w=%0d h=%0d color=0x%03h", x0, y0, w, h, color);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (!(busy === 1'b0 && bus.cmd_ready === 1'b1 && exp_addr.size() == 0 &&
                 exp_done.size() == 0) && guard < 500) begin
            tick();
            guard++;
        end
        if (guard >= 500) check("idle_timeout", 0, 1);
        tick();
    endtask

    initial begin
        int a1[8];
        int tog_g[5];
        int tog_a[5];
        int guard;
        int start;
        a1    = '{0, 1, 2, 3, 320, 321, 322, 323};
        tog_g = '{1, 0, 1, 0, 1};
        tog_a = '{325, 326, 326, 327, 327};

        reset = 1'b1;
        vblank = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_x0 = '0;
        bus.cmd_y0 = '0;
        bus.cmd_w = '0;
        bus.cmd_h = '0;
        bus.cmd_color = '0;
        bus.fb_grant = 1'b1;
        repeat (3) tick();
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_fb_wen", bus.fb_wen, 0);
        check("rst_fb_addr", bus.fb_addr, 0);
        check("rst_fb_din", bus.fb_din, 0);
        check("rst_busy", busy, 0);
        check("rst_done_int", done_int, 0);
        reset = 1'b0;
        tick();

        // 4x2 at origin
        for (int i = 0; i < 8; i++) push_wr(a1[i], 12'hF00);
        issue(0, 0, 4, 2, 12'hF00, 1 + VBL, 9 + VBL);
        wait_idle();

        // Bottom-right clip to 2x1
        push_wr(76798, 12'h0F0);
        push_wr(76799, 12'h0F0);
        issue(318, 239, 10, 5, 12'h0F0, 1 + VBL, 3 + VBL);
        wait_idle();

        // Empty commands
        issue(10, 10, 0, 3, 12'h123, -1, 1);
        wait_idle();
        issue(320, 0, 5, 5, 12'h456, -1, 1);
        wait_idle();

        // Grant toggling 1,0,1,0,1
        push_wr(325, 12'hABC);
        push_wr(326, 12'hABC);
        push_wr(327, 12'hABC);
        issue(5, 1, 3, 1, 12'hABC, 1 + VBL, 6 + VBL);
        guard = 0;
        while (bus.fb_wen !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) check("toggle_wen_timeout", 0, 1);
        for (int i = 0; i < 5; i++) begin
            bus.fb_grant = tog_g[i][0];
            #1;
            check("toggle_addr", bus.fb_addr, tog_a[i]);
            tick();
        end
        bus.fb_grant = 1'b1;
        wait_idle();

        // Reset after 3 committed writes of a 4x4 fill at (100,50): base 16100
        push_wr(16100, 12'h5A5);
        push_wr(16101, 12'h5A5);
        push_wr(16102, 12'h5A5);
        start = wr_count;
        issue(100, 50, 4, 4, 12'h5A5, 1 + VBL, -4);
        guard = 0;
        while (wr_count - start < 3 && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) check("reset_test_timeout", 0, 1);
        reset = 1'b1;
        bus.fb_grant = 1'b0;
        tick();
        check("midrst_fb_wen", bus.fb_wen, 0);
        check("midrst_busy", busy, 0);
        check("midrst_cmd_ready", bus.cmd_ready, 1);
        check("midrst_done_int", done_int, 0);
        reset = 1'b0;
        bus.fb_grant = 1'b1;
        cur_first = -3;
        tick();
        check("midrst_no_done", done_int, 0);
        push_wr(320, 12'h123);
        push_wr(321, 12'h123);
        push_wr(640, 12'h123);
        push_wr(641, 12'h123);
        issue(0, 1, 2, 2, 12'h123, 1 + VBL, 5 + VBL);
        wait_idle();

        // Second command held valid while the first is busy
        push_wr(7, 12'h777);
        push_wr(8, 12'h888);
        issue(7, 0, 1, 1, 12'h777, 1 + VBL, 2 + VBL);
        issue(8, 0, 1, 1, 12'h888, 1 + VBL, 2 + VBL);
        wait_idle();

`ifdef FB_RECT_FILL_VBLANK_SYNC_EN
        vblank = 1'b0;
        push_wr(0, 12'hFFF);
        push_wr(1, 12'hFFF);
        issue(0, 0, 2, 1, 12'hFFF, -3, -3);
        for (int i = 0; i < 50; i++) begin
            check("vbl_wait_no_wen", bus.fb_wen, 0);
            tick();
        end
        vblank = 1'b1;
        check("vbl_rise_no_wen", bus.fb_wen, 0);
        tick();
        check("vbl_first_wen", bus.fb_wen, 1);
        wait_idle();
`endif

        check("leftover_writes", exp_addr.size(), 0);
        check("leftover_dones", exp_done.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
